// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the clocked memory bus controller:
// FSM state encoding, region codes and wait-counter width.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam logic REGION_ROM = 1'b0;
   localparam logic REGION_RAM = 1'b1;

   localparam int WAIT_W = 4;

   // Wait-state count for the region selected by the request address MSB.
   function automatic logic [WAIT_W-1:0] region_wait(input logic              region,
                                                     input logic [WAIT_W-1:0] rom_w,
                                                     input logic [WAIT_W-1:0] ram_w);
      return (region == REGION_RAM) ? ram_w : rom_w;
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that paces the strobe phase; it stops at zero and
// reports zero so the controller knows the last strobe cycle has arrived.
module mem_wait_counter
   import mem_bus_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [WAIT_W-1:0] load_val,
   input  logic              en,
   output logic              zero
);

   logic [WAIT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Clocked ROM/RAM bus controller: one access at a time, sequenced through
// SETUP/ACCESS/DONE with per-region wait states and a tristate data bus.
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int ROM_WAIT   = 2,
   parameter int RAM_WAIT   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_read,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-2:0] ext_addr,
   output logic                  ext_rom_ram,
   output logic                  ext_read,
   output logic                  ext_write,
   inout  wire  [DATA_WIDTH-1:0] ext_data
);

   localparam logic [WAIT_W-1:0] ROM_W = WAIT_W'(ROM_WAIT);
   localparam logic [WAIT_W-1:0] RAM_W = WAIT_W'(RAM_WAIT);

   // Request handshake: req_read/req_write act as a valid that is only taken
   // while busy is low (FSM in IDLE); every request seen while busy is high is
   // dropped, and each taken request ends with exactly one done pulse.
   state_e                state_q, state_d;
   logic [ADDR_WIDTH-2:0] ext_addr_q, ext_addr_d;
   logic                  region_q, region_d;
   logic                  is_read_q, is_read_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_lat_q, err_lat_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  rd_stb_q, rd_stb_d;
   logic                  wr_stb_q, wr_stb_d;
   logic                  drive_q, drive_d;

   logic                  req_region;
   logic                  req_illegal;
   logic                  req_valid;
   logic                  cnt_load;
   logic                  cnt_en;
   logic                  cnt_zero;

   mem_wait_counter u_wait (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (region_wait(req_region, ROM_W, RAM_W)),
      .en       (cnt_en),
      .zero     (cnt_zero)
   );

   always_comb begin
      req_region  = req_addr[ADDR_WIDTH-1];
      req_illegal = (req_read && req_write) || (req_write && (req_region == REGION_ROM));
      req_valid   = (req_read ^ req_write) && !req_illegal;

      state_d    = state_q;
      ext_addr_d = ext_addr_q;
      region_d   = region_q;
      is_read_d  = is_read_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_lat_d  = err_lat_q;
      cnt_load   = 1'b0;
      cnt_en     = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_illegal) begin
               err_lat_d = 1'b1;
               state_d   = DONE;
            end else if (req_valid) begin
               ext_addr_d = req_addr[ADDR_WIDTH-2:0];
               region_d   = req_region;
               is_read_d  = req_read;
               wdata_d    = wdata;
               err_lat_d  = 1'b0;
               cnt_load   = 1'b1;
               state_d    = SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            cnt_en = 1'b1;
            if (cnt_zero) begin
               if (is_read_q) begin
                  rdata_d = ext_data;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      busy_d   = (state_d != IDLE);
      done_d   = (state_d == DONE);
      err_d    = (state_d == DONE) && err_lat_d;
      rd_stb_d = (state_d == ACCESS) && is_read_d;
      wr_stb_d = (state_d == ACCESS) && !is_read_d;
      drive_d  = ((state_d == SETUP) || (state_d == ACCESS)) && !is_read_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ext_addr_q <= '0;
         region_q   <= REGION_ROM;
         is_read_q  <= 1'b1;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_lat_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rd_stb_q   <= 1'b0;
         wr_stb_q   <= 1'b0;
         drive_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ext_addr_q <= ext_addr_d;
         region_q   <= region_d;
         is_read_q  <= is_read_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         err_lat_q  <= err_lat_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         rd_stb_q   <= rd_stb_d;
         wr_stb_q   <= wr_stb_d;
         drive_q    <= drive_d;
      end
   end

   assign rdata       = rdata_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign ext_addr    = ext_addr_q;
   assign ext_rom_ram = region_q;
   assign ext_read    = rd_stb_q;
   assign ext_write   = wr_stb_q;
   assign ext_data    = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: a vector table of single accesses plus
// hand-written sequences for reset mid-access and back-to-back requests.
module tb_mem_bus_ctrl;

   logic        clk;
   logic        reset;
   logic        req_read;
   logic        req_write;
   logic [15:0] req_addr;
   logic [7:0]  wdata;
   wire  [7:0]  rdata;
   wire         busy;
   wire         done;
   wire         err;
   wire  [14:0] ext_addr;
   wire         ext_rom_ram;
   wire         ext_read;
   wire         ext_write;
   wire  [7:0]  ext_data;

   logic        tb_en;
   logic [7:0]  tb_val;

   assign ext_data = tb_en ? tb_val : 8'bz;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];

   mem_bus_ctrl #(
      .ADDR_WIDTH (16),
      .DATA_WIDTH (8),
      .ROM_WAIT   (2),
      .RAM_WAIT   (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_read    (req_read),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .wdata       (wdata),
      .rdata       (rdata),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .ext_addr    (ext_addr),
      .ext_rom_ram (ext_rom_ram),
      .ext_read    (ext_read),
      .ext_write   (ext_write),
      .ext_data    (ext_data)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  wd;
      logic [7:0]  bus;
      logic        exp_err;
      logic        exp_rr;
      logic [14:0] exp_ea;
      int          exp_w;
      logic [7:0]  exp_rdata;
   } vec_t;

   vec_t vecs[8];
   vec_t post_rst;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Drive one request, follow it to its done pulse, then check the record.
   task automatic run_vec(input vec_t v, input int idx);
      int         done_cyc;
      int         rd_cnt;
      int         wr_cnt;
      int         busy_cnt;
      int         exp_done;
      logic       err_seen;
      logic [7:0] rd_at_done;
      logic [14:0] ea1;
      logic       rr1;
      logic       wbus_ok;
      logic       rel_ok;
      logic       idle_after;
      logic       is_wr;
      string      tag;

      tag        = $sformatf("v%0d", idx);
      is_wr      = v.wr && !v.rd;
      done_cyc   = 0;
      rd_cnt     = 0;
      wr_cnt     = 0;
      busy_cnt   = 0;
      err_seen   = 1'b0;
      rd_at_done = 8'h00;
      ea1        = '0;
      rr1        = 1'b0;
      wbus_ok    = 1'b1;
      rel_ok     = 1'b1;
      exp_q.push_back(v.exp_rdata);

      req_read  = v.rd;
      req_write = v.wr;
      req_addr  = v.addr;
      wdata     = v.wd;
      tb_en     = v.rd && !v.wr;
      tb_val    = v.bus;
      @(posedge clk);
      #1;
      req_read  = 1'b0;
      req_write = 1'b0;

      for (int k = 1; (k <= 24) && (done_cyc == 0); k++) begin
         @(negedge clk);
         if (k == 1) begin
            ea1 = ext_addr;
            rr1 = ext_rom_ram;
         end
         if (busy)      busy_cnt++;
         if (ext_read)  rd_cnt++;
         if (ext_write) wr_cnt++;
         if (done) begin
            done_cyc   = k;
            err_seen   = err;
            rd_at_done = rdata;
            if (is_wr && (ext_data === v.wd)) rel_ok = 1'b0;
         end else if (is_wr && !v.exp_err && (ext_data !== v.wd)) begin
            wbus_ok = 1'b0;
         end
      end
      @(negedge clk);
      idle_after = !busy && !done;
      tb_en = 1'b0;

      exp_done = v.exp_err ? 1 : 3 + v.exp_w;
      chk({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
      chk({tag, " err"}, 32'(err_seen), 32'(v.exp_err));
      chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_done));
      chk({tag, " read_strobe_cycles"}, 32'(rd_cnt), (v.rd && !v.exp_err) ? 32'(v.exp_w + 1) : 32'd0);
      chk({tag, " write_strobe_cycles"}, 32'(wr_cnt), (v.wr && !v.exp_err) ? 32'(v.exp_w + 1) : 32'd0);
      chk({tag, " ext_addr"}, 32'(ea1), 32'(v.exp_ea));
      chk({tag, " ext_rom_ram"}, 32'(rr1), 32'(v.exp_rr));
      chk({tag, " rdata"}, 32'(rd_at_done), 32'(exp_q.pop_front()));
      chk({tag, " idle_after_done"}, 32'(idle_after), 32'd1);
      if (is_wr && !v.exp_err) chk({tag, " write_data_driven"}, 32'(wbus_ok), 32'd1);
      if (is_wr) chk({tag, " bus_released_in_done"}, 32'(rel_ok), 32'd1);
   endtask

   initial begin : main
      logic        seen_done;
      logic [12:1] busy_bits;
      logic [12:1] rd_bits;
      logic [12:1] wr_bits;
      logic [12:1] busy_exp;
      logic [12:1] rd_exp;
      logic [7:0]  rdata_c4;
      logic [7:0]  rdata_c9;

      // rd wr addr     wd     bus    err   rr    ea        W  rdata
      vecs[0] = '{1'b1, 1'b0, 16'h8012, 8'h00, 8'hA5, 1'b0, 1'b1, 15'h0012, 1, 8'hA5};
      vecs[1] = '{1'b1, 1'b0, 16'h0100, 8'h00, 8'h3C, 1'b0, 1'b0, 15'h0100, 2, 8'h3C};
      vecs[2] = '{1'b0, 1'b1, 16'hFFFF, 8'h5A, 8'h00, 1'b0, 1'b1, 15'h7FFF, 1, 8'h3C};
      vecs[3] = '{1'b0, 1'b1, 16'h7FFF, 8'h99, 8'h00, 1'b1, 1'b1, 15'h7FFF, 0, 8'h3C};
      vecs[4] = '{1'b1, 1'b1, 16'h1234, 8'h77, 8'h00, 1'b1, 1'b1, 15'h7FFF, 0, 8'h3C};
      vecs[5] = '{1'b1, 1'b0, 16'h7FFE, 8'h00, 8'hFF, 1'b0, 1'b0, 15'h7FFE, 2, 8'hFF};
      vecs[6] = '{1'b1, 1'b0, 16'h8000, 8'h00, 8'h66, 1'b0, 1'b1, 15'h0000, 1, 8'h66};
      vecs[7] = '{1'b0, 1'b1, 16'h8ABC, 8'hC3, 8'h00, 1'b0, 1'b1, 15'h0ABC, 1, 8'h66};
      post_rst = '{1'b1, 1'b0, 16'h8077, 8'h00, 8'hE1, 1'b0, 1'b1, 15'h0077, 1, 8'hE1};

      // reset
      reset     = 1'b1;
      req_read  = 1'b0;
      req_write = 1'b0;
      req_addr  = 16'h0000;
      wdata     = 8'h00;
      tb_en     = 1'b0;
      tb_val    = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("reset rdata", 32'(rdata), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      chk("reset ext_read", 32'(ext_read), 32'd0);
      chk("reset ext_write", 32'(ext_write), 32'd0);
      chk("reset ext_addr", 32'(ext_addr), 32'd0);
      chk("reset ext_rom_ram", 32'(ext_rom_ram), 32'd0);

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i], i);
      end

      // reset in the second ACCESS cycle of a ROM read (W=2)
      req_read = 1'b1;
      req_addr = 16'h0200;
      tb_en    = 1'b1;
      tb_val   = 8'h77;
      @(posedge clk);
      #1;
      req_read = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid strobe_before", 32'(ext_read), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid ext_read", 32'(ext_read), 32'd0);
      chk("rst_mid ext_write", 32'(ext_write), 32'd0);
      chk("rst_mid busy", 32'(busy), 32'd0);
      chk("rst_mid rdata", 32'(rdata), 32'd0);
      chk("rst_mid done", 32'(done), 32'd0);
      reset = 1'b0;
      tb_en = 1'b0;
      seen_done = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      chk("rst_mid no_done_after", 32'(seen_done), 32'd0);
      run_vec(post_rst, 8);

      // back-to-back RAM reads (W=1) with the request held, then a write while busy
      busy_bits = '0;
      rd_bits   = '0;
      wr_bits   = '0;
      rdata_c4  = 8'h00;
      rdata_c9  = 8'h00;
      req_read  = 1'b1;
      req_addr  = 16'h8044;
      tb_en     = 1'b1;
      tb_val    = 8'h11;
      @(posedge clk);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         busy_bits[k] = busy;
         rd_bits[k]   = ext_read;
         wr_bits[k]   = ext_write;
         if (k == 4) rdata_c4 = rdata;
         if (k == 9) rdata_c9 = rdata;
         if (k == 5) tb_val = 8'h22;
         if (k == 6) begin
            req_read  = 1'b0;
            req_write = 1'b1;
            req_addr  = 16'h8055;
            wdata     = 8'hAA;
         end
         if (k == 8) begin
            req_read  = 1'b0;
            req_write = 1'b0;
         end
      end
      tb_en = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         busy_exp[k] = ((k >= 1) && (k <= 4)) || ((k >= 6) && (k <= 9));
         rd_exp[k]   = (k == 2) || (k == 3) || (k == 7) || (k == 8);
      end
      chk("b2b busy_pattern", 32'(busy_bits), 32'(busy_exp));
      chk("b2b read_pattern", 32'(rd_bits), 32'(rd_exp));
      chk("b2b write_ignored", 32'(wr_bits), 32'd0);
      chk("b2b ext_addr_held", 32'(ext_addr), 32'h0044);
      chk("b2b rdata_first", 32'(rdata_c4), 32'h11);
      chk("b2b rdata_second", 32'(rdata_c9), 32'h22);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Parametrised, clocked memory bus controller that replaces the purely combinational memory interface between the CPU datapath and the external ROM/RAM bus. It accepts one read or write request at a time from the core and splits the address into a region select and an external address. It sequences each access through setup, strobe and completion phases, with a per-region number of wait states. It drives and releases the bidirectional external data bus, captures read data into a register, and reports illegal requests (simultaneous read and write, or a write to ROM) as errors instead of starting an access.

## Interface
Parameters:
- ADDR_WIDTH, 16: core address width; the MSB selects the region.
- DATA_WIDTH, 8: data bus width.
- ROM_WAIT, 2: wait states for region 0 (ROM); 0..15.
- RAM_WAIT, 1: wait states for region 1 (RAM); 0..15.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- req_read  in  1  read request, sampled in IDLE
- req_write  in  1  write request, sampled in IDLE
- req_addr  in  ADDR_WIDTH  request address
- wdata  in  DATA_WIDTH  write data
- rdata  out  DATA_WIDTH  registered read data; holds its value until the next successful read
- busy  out  1  high while an access or an error response is in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error flag, coincident with done
- ext_addr  out  ADDR_WIDTH-1  external address, equal to req_addr[ADDR_WIDTH-2:0]
- ext_rom_ram  out  1  region select: 1 = RAM, 0 = ROM
- ext_read  out  1  read strobe, active high
- ext_write  out  1  write strobe, active high
- ext_data  inout  DATA_WIDTH  external data bus; tristated except while the controller drives a write

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE, valid request (exactly one of req_read/req_write high, and not a write with req_addr MSB = 0):
  - latch the address, wdata, direction and region;
  - load the wait counter with the region's wait-state count;
  - next state is SETUP.
- IDLE, illegal request (both req_read and req_write high, or a write to ROM):
  - latch err;
  - next state is DONE; no strobe is asserted.
- IDLE, no request: remain in IDLE.
- SETUP:
  - ext_addr and ext_rom_ram carry the latched values;
  - strobes stay low; a write drives ext_data;
  - next state is ACCESS.
- ACCESS:
  - the strobe for the latched direction is high;
  - the counter decrements each cycle;
  - when the counter is 0, a read captures ext_data into rdata on that edge, and the next state is DONE.
- DONE:
  - strobes are low and ext_data is released;
  - done = 1, err = latched error flag;
  - next state is IDLE.
- Requests are ignored in every state other than IDLE. The requester must wait for busy = 0.
- Outside SETUP/ACCESS, ext_addr and ext_rom_ram hold their last values. They are 0 after reset.

## Timing
- Reset values: state = IDLE; rdata = 0, busy = 0, done = 0, err = 0, ext_read = 0, ext_write = 0, ext_addr = 0, ext_rom_ram = 0; ext_data is high-Z.
- Valid access, request sampled at edge E0, W = wait states for the region:
  - SETUP occupies cycle 1.
  - ACCESS occupies cycles 2 to 2+W; the strobe is high for W+1 cycles.
  - DONE is cycle 3+W; rdata is valid from that cycle.
  - IDLE resumes in cycle 4+W.
  - Total: 4+W cycles from request to a new request being accepted.
- Error response: err/done are high in cycle 1; IDLE resumes in cycle 2.
- busy is high in SETUP, ACCESS and DONE. It is a registered output.
- ext_data is driven only in SETUP and ACCESS of a write. It is never driven in the same cycle as ext_read.
- Reset asserted mid-access: on the next edge the state returns to IDLE, strobes drop, ext_data is released, and no done pulse is produced. rdata is cleared to 0.

## Structure
- Package mem_bus_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, DONE);
  - region constants REGION_ROM = 0 and REGION_RAM = 1;
  - the wait-counter width WAIT_W = 4.
- Sub-module mem_wait_counter: a loadable 4-bit down-counter with load, enable and a zero flag, instantiated once.

## Test plan
- RAM read, RAM_WAIT = 1: addr 16'h8012 with ext_data = 8'hA5 -> ext_rom_ram = 1, ext_addr = 15'h0012, ext_read high 2 cycles, done in cycle 4, rdata = 8'hA5.
- ROM read, ROM_WAIT = 2: addr 16'h0100 with ext_data = 8'h3C -> ext_rom_ram = 0, ext_read high 3 cycles, done in cycle 5, rdata = 8'h3C.
- RAM write, addr 16'hFFFF, wdata 8'h5A:
  - ext_addr = 15'h7FFF;
  - ext_data = 8'h5A during SETUP and ACCESS;
  - ext_write high for 2 cycles;
  - ext_data is Z in DONE.
- Write to ROM at addr 16'h7FFF, then req_read and req_write high together: each produces done = err = 1 in cycle 1 with no strobe, and busy low again in cycle 2.
- Reset asserted in the second ACCESS cycle of a ROM read -> next cycle: all strobes low, ext_data Z, busy = 0, rdata = 0, no done pulse; the next request is accepted normally.
- Back-to-back reads with the request held high -> the second access's SETUP starts in cycle 5+W of the first; a request made while busy is ignored.
